// File: rtl/demux_stream.sv
// Registered 1:N packet demultiplexer with valid/ready on every port.
// The first beat selects the channel; out-of-range selects drop the whole packet and bump drop_cnt.
module demux_stream #(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [SW-1:0]  in_sel,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_valid,
  output logic [N-1:0]   out_last,
  input  logic [N-1:0]   out_ready,
  output logic [7:0]     drop_cnt
);

  // state | meaning
  // IDLE  | waiting for the first beat of a packet
  // BUSY  | mid-packet, beats go to the locked channel
  // DROP  | mid-packet with an out-of-range select, beats discarded
  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t        state, state_n;
  logic [SW-1:0] ch_q, ch_n;
  logic [SW-1:0] cur_ch;
  logic          sel_ok;
  logic          discard;
  logic          accept;
  logic          load;
  logic          cur_valid;
  logic          cur_ready;

  assign sel_ok  = (32'(in_sel) < 32'(N));
  assign cur_ch  = (state == IDLE) ? in_sel : ch_q;
  assign discard = (state == DROP) || ((state == IDLE) && !sel_ok);

  always_comb begin
    cur_valid = 1'b0;
    cur_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cur_ch == SW'(k)) begin
        cur_valid = out_valid[k];
        cur_ready = out_ready[k];
      end
    end
  end

  // in_ready never looks at in_valid, so the upstream side cannot form a loop through us
  assign in_ready = discard ? 1'b1 : (~cur_valid | cur_ready);
  assign accept   = in_valid & in_ready;
  assign load     = accept & ~discard;

  always_comb begin
    state_n = state;
    ch_n    = ch_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!sel_ok) begin
            state_n = in_last ? IDLE : DROP;
          end else begin
            ch_n    = in_sel;
            state_n = in_last ? IDLE : BUSY;
          end
        end
      end
      BUSY: if (accept && in_last) state_n = IDLE;
      DROP: if (accept && in_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ch_q  <= '0;
    end else begin
      state <= state_n;
      ch_q  <= ch_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && (state == IDLE) && !sel_ok && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // A load on the same edge as a drain keeps the channel valid with the new beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load && (cur_ch == SW'(k))) begin
          out_valid[k]         <= 1'b1;
          out_data[k*W +: W]   <= in_data;
          out_last[k]          <= in_last;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed checks of demux_stream: a 4-channel instance for routing/back-pressure
// and a 3-channel instance so select value 3 is out of range and gets dropped.
module tb_demux_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [1:0]  in_sel = '0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_last;
  logic [3:0]  out_ready = '0;
  logic [7:0]  drop_cnt;

  logic        d_valid = 1'b0;
  logic        d_in_ready;
  logic [23:0] d_out_data;
  logic [2:0]  d_out_valid;
  logic [2:0]  d_out_last;
  logic [2:0]  d_out_ready = 3'b111;
  logic [7:0]  d_drop_cnt;

  int checks = 0;
  int errors = 0;
  logic rdy_m, rdy_d;

  always #5 clk = ~clk;

  demux_stream #(.W(8), .N(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_sel(in_sel), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  demux_stream #(.W(8), .N(3)) u_drop (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(d_valid), .in_last(in_last),
    .in_sel(in_sel), .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
    .out_last(d_out_last), .out_ready(d_out_ready), .drop_cnt(d_drop_cnt)
  );

  // One cycle of stimulus: present the beat, sample in_ready before the edge, return 1 after it
  task automatic cyc(input logic to_drop, input logic v, input logic [1:0] s,
                     input logic [7:0] d, input logic l);
    in_sel   = s;
    in_data  = d;
    in_last  = l;
    in_valid = v & ~to_drop;
    d_valid  = v & to_drop;
    @(negedge clk);
    rdy_m = in_ready;
    rdy_d = d_in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    d_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    out_ready = 4'b0000;
    @(negedge clk);
    checks++;
    if (out_valid !== 4'b0 || out_data !== 32'h0 || out_last !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b, want 0", out_valid, out_data, out_last);
    end
    checks++;
    if (drop_cnt !== 8'd0 || d_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d/%0d, want 0", drop_cnt, d_drop_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_beats;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 2'(k), 8'hA0 + 8'(k), 1'b1);
      checks++;
      if (out_valid !== (4'b0001 << k) || out_data[k*8 +: 8] !== 8'hA0 + 8'(k) || out_last[k] !== 1'b1) begin
        errors++;
        $display("FAIL single_beat ch%0d: valid=%b data=%h last=%b, want valid=%b data=%h last=1",
                 k, out_valid, out_data[k*8 +: 8], out_last[k], 4'b0001 << k, 8'hA0 + 8'(k));
      end
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_drain: valid=%b, want 0000", out_valid);
    end
  endtask

  task automatic test_sel_toggle;
    out_ready = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      cyc(1'b0, 1'b1, (b == 0) ? 2'd2 : 2'd1, 8'hB0 + 8'(b), (b == 3));
      checks++;
      if (rdy_m !== 1'b1 || out_valid !== 4'b0100 || out_data[23:16] !== 8'hB0 + 8'(b) ||
          out_last[2] !== (b == 3)) begin
        errors++;
        $display("FAIL sel_toggle beat%0d: rdy=%b valid=%b data=%h last=%b, want rdy=1 valid=0100 data=%h last=%0d",
                 b, rdy_m, out_valid, out_data[23:16], out_last[2], 8'hB0 + 8'(b), (b == 3));
      end
    end
    cyc(1'b0, 1'b1, 2'd1, 8'hB9, 1'b1);
    checks++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'hB9) begin
      errors++;
      $display("FAIL sel_toggle_idle: valid=%b data1=%h, want valid=0010 data1=b9", out_valid, out_data[15:8]);
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic test_backpressure;
    out_ready = 4'b1011;
    cyc(1'b0, 1'b1, 2'd2, 8'hC0, 1'b0);
    checks++;
    if (rdy_m !== 1'b1 || out_valid !== 4'b0100 || out_data[23:16] !== 8'hC0) begin
      errors++;
      $display("FAIL bp_first: rdy=%b valid=%b data=%h, want rdy=1 valid=0100 data=c0", rdy_m, out_valid, out_data[23:16]);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 2'd0, 8'hC1, 1'b0);
      checks++;
      if (rdy_m !== 1'b0 || out_valid !== 4'b0100 || out_data[23:16] !== 8'hC0 || out_last[2] !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: rdy=%b valid=%b data=%h last=%b, want rdy=0 valid=0100 data=c0 last=0",
                 i, rdy_m, out_valid, out_data[23:16], out_last[2]);
      end
    end
    out_ready = 4'b1111;
    cyc(1'b0, 1'b1, 2'd0, 8'hC1, 1'b0);
    checks++;
    if (rdy_m !== 1'b1 || out_valid !== 4'b0100 || out_data[23:16] !== 8'hC1) begin
      errors++;
      $display("FAIL bp_resume: rdy=%b valid=%b data=%h, want rdy=1 valid=0100 data=c1", rdy_m, out_valid, out_data[23:16]);
    end
    cyc(1'b0, 1'b1, 2'd0, 8'hC2, 1'b1);
    checks++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hC2 || out_last[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_last: valid=%b data=%h last=%b, want valid=0100 data=c2 last=1", out_valid, out_data[23:16], out_last[2]);
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 4'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b, want 0000", out_valid);
    end
  endtask

  task automatic test_drop;
    d_out_ready = 3'b111;
    for (int b = 0; b < 3; b++) begin
      cyc(1'b1, 1'b1, 2'd3, 8'hD0 + 8'(b), (b == 2));
      checks++;
      if (rdy_d !== 1'b1 || d_out_valid !== 3'b000 || d_drop_cnt !== 8'd1) begin
        errors++;
        $display("FAIL drop_pkt beat%0d: rdy=%b valid=%b cnt=%0d, want rdy=1 valid=000 cnt=1",
                 b, rdy_d, d_out_valid, d_drop_cnt);
      end
    end
    cyc(1'b1, 1'b1, 2'd0, 8'h55, 1'b1);
    checks++;
    if (d_out_valid !== 3'b001 || d_out_data[7:0] !== 8'h55 || d_drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL drop_then_route: valid=%b data=%h cnt=%0d, want valid=001 data=55 cnt=1",
               d_out_valid, d_out_data[7:0], d_drop_cnt);
    end
    for (int i = 0; i < 254; i++) cyc(1'b1, 1'b1, 2'd3, 8'(i), 1'b1);
    checks++;
    if (d_drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_cnt_255: got %0d, want 255", d_drop_cnt);
    end
    cyc(1'b1, 1'b1, 2'd3, 8'h77, 1'b1);
    checks++;
    if (d_drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_cnt_sat: got %0d, want 255", d_drop_cnt);
    end
    cyc(1'b1, 1'b1, 2'd1, 8'h66, 1'b1);
    checks++;
    if (d_out_valid !== 3'b010 || d_out_data[15:8] !== 8'h66) begin
      errors++;
      $display("FAIL drop_single_idle: valid=%b data=%h, want valid=010 data=66", d_out_valid, d_out_data[15:8]);
    end
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    out_ready = 4'b1101;
    cyc(1'b0, 1'b1, 2'd1, 8'hE0, 1'b0);
    cyc(1'b0, 1'b1, 2'd1, 8'hE1, 1'b0);
    checks++;
    if (rdy_m !== 1'b0 || out_valid !== 4'b0010 || out_data[15:8] !== 8'hE0) begin
      errors++;
      $display("FAIL rstmid_hold: rdy=%b valid=%b data=%h, want rdy=0 valid=0010 data=e0", rdy_m, out_valid, out_data[15:8]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0 || out_data !== 32'h0 || d_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b data=%h dcnt=%0d, want 0", out_valid, out_data, d_drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 2'd0, 8'hE2, 1'b1);
    checks++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'hE2) begin
      errors++;
      $display("FAIL rstmid_first: valid=%b data0=%h, want valid=0001 data0=e2", out_valid, out_data[7:0]);
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    out_ready = 4'b1111;
    cyc(1'b0, 1'b1, 2'd0, 8'hF0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 8'hF1, 1'b1);
    checks++;
    if (rdy_m !== 1'b1 || out_valid !== 4'b0001 || out_data[7:0] !== 8'hF1) begin
      errors++;
      $display("FAIL b2b_same_edge: rdy=%b valid=%b data0=%h, want rdy=1 valid=0001 data0=f1", rdy_m, out_valid, out_data[7:0]);
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic test_soak;
    logic [7:0] exp_q [4][$];
    logic [7:0] exp;
    logic [1:0] pkt_ch;
    logic       in_pkt;
    pkt_ch = 2'd0;
    in_pkt = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_sel    = 2'($urandom_range(0, 3));
        in_data   = 8'($urandom);
        in_last   = ($urandom_range(0, 2) == 0);
        out_ready = 4'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = 4'b1111;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL soak_extra ch%0d: got %h, want nothing", k, out_data[k*8 +: 8]);
          end else begin
            exp = exp_q[k].pop_front();
            if (out_data[k*8 +: 8] !== exp) begin
              errors++;
              $display("FAIL soak_order ch%0d: got %h, want %h", k, out_data[k*8 +: 8], exp);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        if (!in_pkt) pkt_ch = in_sel;
        exp_q[pkt_ch].push_back(in_data);
        in_pkt = !in_last;
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (exp_q[k].size() != 0 || out_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL soak_residue ch%0d: pending=%0d valid=%b, want 0", k, exp_q[k].size(), out_valid[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beats();
    test_sel_toggle();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
